// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg
// Purpose: types and constants shared by the count controller and its users.
//   state_t               : controller FSM states (IDLE, LOAD, RUN, DONE)
//   COUNT_DEFAULT_WIDTH   : default counter width in bits
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int COUNT_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/count_ctrl_fsm.sv
// count_ctrl_fsm
// Purpose: sequences an external loadable counter through one run per
// accepted command. A run loads cmd_start into the counter, enables it until
// its fed-back value equals cmd_stop (wrapping modulo 2^WIDTH), then pulses
// done for one cycle.
//
// Optional feature: define COUNT_CTRL_PAUSE_EN to add a pause input that
// freezes the counter in RUN without ending the run.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   cmd_valid  in   run request present
//   cmd_ready  out  controller can accept a request (IDLE, no abort)
//   cmd_start  in   first count value
//   cmd_stop   in   terminal count value
//   abort      in   cancels the run in progress, no done pulse
//   pause      in   (COUNT_CTRL_PAUSE_EN only) hold the counter while in RUN
//   count      in   current value fed back from the external counter
//   load       out  one-cycle load strobe to the counter
//   load_value out  value the counter loads, held until the next handshake
//   en         out  count enable to the counter
//   busy       out  a run is in progress
//   done       out  one-cycle pulse when a run completes
module count_ctrl_fsm
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH = COUNT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_stop,
  input  logic             abort,
`ifdef COUNT_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [WIDTH-1:0] count,
  output logic             load,
  output logic [WIDTH-1:0] load_value,
  output logic             en,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] stop_q;
  logic             at_stop;
  logic             hold;

  assign at_stop = (count == stop_q);

`ifdef COUNT_CTRL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // en must follow the fed-back count within the same cycle so the counter
  // stops exactly on stop_q; it is therefore decoded from the state rather
  // than registered. Async reset of state clears it immediately.
  assign en        = (state == RUN) && !at_stop && !hold;
  assign cmd_ready = (state == IDLE) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      load_value <= '0;
      stop_q     <= '0;
      load       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Strobes default low; they are set only on entry to their state.
      load <= 1'b0;
      done <= 1'b0;
      if (abort) begin
        // Abort wins over completion and over a new handshake.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              load_value <= cmd_start;
              stop_q     <= cmd_stop;
              state      <= LOAD;
              load       <= 1'b1;
              busy       <= 1'b1;
            end
          end
          LOAD: begin
            state <= RUN;
          end
          RUN: begin
            if (at_stop && !hold) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_ctrl_fsm.sv
// tb_count_ctrl_fsm
// Purpose: self-checking bench for count_ctrl_fsm with a behavioural loadable
// counter closing the count loop. Each accepted command pushes its expected
// load value, enable count and done latency to a scoreboard; a negedge
// monitor pops and compares when done pulses.
// Define COUNT_CTRL_PAUSE_EN to also exercise the pause input.
module tb_count_ctrl_fsm;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cmd_start = '0;
  logic [W-1:0] cmd_stop = '0;
  logic [W-1:0] count = '0;
  logic         cmd_ready;
  logic         load;
  logic [W-1:0] load_value;
  logic         en;
  logic         busy;
  logic         done;
`ifdef COUNT_CTRL_PAUSE_EN
  logic         pause = 1'b0;
`endif

  count_ctrl_fsm #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_stop   (cmd_stop),
    .abort      (abort),
`ifdef COUNT_CTRL_PAUSE_EN
    .pause      (pause),
`endif
    .count      (count),
    .load       (load),
    .load_value (load_value),
    .en         (en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // External loadable counter.
  always @(posedge clk) begin
    if (load)    count <= load_value;
    else if (en) count <= count + 1'b1;
  end

  typedef struct {
    int start;
    int stop;
    int exp_en;
    int exp_lat;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int load_cyc = 0;
  int en_cnt = 0;
  int load_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      if (en) en_cnt++;
      if (load) begin
        load_cnt++;
        if (sb.size() == 0) begin
          check_val("unexpected_load", 1, 0);
        end else begin
          check_val("load_value", load_value, sb[0].start);
          load_cyc = cyc;
          en_cnt   = 0;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          check_val("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("run start=%0d stop=%0d en=%0d lat=%0d", e.start, e.stop, en_cnt, cyc - load_cyc + 1);
          check_val("en_cycles", en_cnt, e.exp_en);
          check_val("latency", cyc - load_cyc + 1, e.exp_lat);
          check_val("load_pulses", load_cnt, 1);
          load_cnt = 0;
        end
      end
    end
  end

  // Issue one command and wait (bounded) for its done pulse.
  task automatic run_cmd(input int start, input int stop, input int pause_cycles);
    exp_t e;
    int   diff;
    int   i;
    diff      = (stop - start) & 255;
    e.start   = start;
    e.stop    = stop;
    e.exp_en  = diff;
    e.exp_lat = 3 + diff + pause_cycles;
    load_cnt  = 0;
    check_val("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_start = W'(start);
    cmd_stop  = W'(stop);
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_val("busy_in_load", busy, 1);
    check_val("ready_in_load", cmd_ready, 0);
`ifdef COUNT_CTRL_PAUSE_EN
    if (pause_cycles > 0) begin
      @(posedge clk); #1;
      pause = 1'b1;
      repeat (pause_cycles) begin
        @(posedge clk); #1;
      end
      pause = 1'b0;
    end
`endif
    i = 0;
    while (sb.size() != 0 && i < 600) begin
      @(posedge clk); #1;
      i++;
    end
    if (sb.size() != 0) begin
      check_val("done_timeout", 0, 1);
      sb.delete();
    end
    check_val("ready_after", cmd_ready, 1);
    check_val("busy_after", busy, 0);
  endtask

  initial begin
    int n;
    int s;
    int d;
    exp_t e;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_load", load, 0);
    check_val("rst_en", en, 0);
    check_val("rst_done", done, 0);
    check_val("rst_load_value", load_value, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("ready_idle", cmd_ready, 1);

    // Main function and boundaries.
    run_cmd(10, 14, 0);
    run_cmd(7, 7, 0);
    run_cmd(250, 3, 0);

    // Abort beats a new handshake in IDLE.
    cmd_valid = 1'b1;
    abort     = 1'b1;
    #1;
    check_val("ready_abort", cmd_ready, 0);
    @(posedge clk); #1;
    check_val("abort_idle_busy", busy, 0);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    @(posedge clk); #1;

    // Abort after two enable cycles of a 10->20 run.
    e.start = 10; e.stop = 20; e.exp_en = 0; e.exp_lat = 0;
    load_cnt  = 0;
    cmd_valid = 1'b1;
    cmd_start = 8'd10;
    cmd_stop  = 8'd20;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(posedge clk); #1;
      if (en) n++;
    end
    check_val("abort_en_seen", n, 2);
    abort = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    check_val("abort_en", en, 0);
    check_val("abort_busy", busy, 0);
    abort = 1'b0;
    #1;
    check_val("abort_ready", cmd_ready, 1);
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset between edges in the middle of RUN.
    load_cnt  = 0;
    cmd_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_val("pre_rst_en", en, 1);
    rst = 1'b1;
    #1;
    sb.delete();
    check_val("arst_en", en, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_load", load, 0);
    check_val("arst_load_value", load_value, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_val("post_rst_ready", cmd_ready, 1);
    check_val("post_rst_busy", busy, 0);
    @(posedge clk); #1;

    // A few random short runs.
    for (int k = 0; k < 4; k++) begin
      s = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 20));
      run_cmd(s, (s + d) & 255, 0);
    end

`ifdef COUNT_CTRL_PAUSE_EN
    run_cmd(0, 5, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_ctrl_fsm.md
COUNT_CTRL_FSM -- requirements
Module: count_ctrl_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the counter width in bits.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  run request is present.
REQ-005 SHALL have port cmd_ready  output  1  controller can accept a request.
REQ-006 SHALL have port cmd_start  input  WIDTH  first count value.
REQ-007 SHALL have port cmd_stop  input  WIDTH  terminal count value.
REQ-008 SHALL have port abort  input  1  cancels the operation in progress.
REQ-009 SHALL have port count  input  WIDTH  current value fed back from the downstream loadable counter.
REQ-010 SHALL have port load  output  1  load strobe to the counter.
REQ-011 SHALL have port load_value  output  WIDTH  value the counter loads.
REQ-012 SHALL have port en  output  1  count enable to the counter.
REQ-013 SHALL have port busy  output  1  an operation is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse when an operation completes.

Function
REQ-015 SHALL implement the Moore states IDLE, LOAD, RUN and DONE.
REQ-016 SHALL drive cmd_ready=1 only in IDLE with abort=0; a handshake occurs when cmd_valid and cmd_ready are both 1 on a rising edge.
REQ-017 SHALL, on a handshake, register cmd_start into load_value and cmd_stop into stop_q, then move to LOAD.
REQ-018 SHALL drive load=1 for exactly one cycle in LOAD, then move to RUN unconditionally.
REQ-019 SHALL drive en = (count != stop_q) in RUN; en SHALL be 0 in every other state.
REQ-020 SHALL move from RUN to DONE on the first RUN cycle in which count == stop_q.
REQ-021 SHALL drive done=1 for exactly one cycle in DONE, then move to IDLE.
REQ-022 SHALL drive busy=1 in LOAD, RUN and DONE, and busy=0 in IDLE.
REQ-023 SHALL give a latency from handshake to done of 3 + ((stop - start) mod 2^WIDTH) cycles.
REQ-024 SHALL, when start == stop, produce zero en cycles and go LOAD -> RUN (one cycle) -> DONE.
REQ-025 SHALL, when stop < start, keep en asserted through the counter's wrap from 2^WIDTH-1 to 0; all arithmetic is modulo 2^WIDTH.
REQ-026 SHALL, when abort=1 in any state, go to IDLE on the next edge with no done pulse; abort has priority over both completion and a new handshake.
REQ-027 SHALL hold load_value stable from the handshake until the next handshake.

Reset
REQ-028 SHALL, while rst=1, force state=IDLE and load_value=0, stop_q=0, load=0, en=0, busy=0, done=0 immediately, independent of clk.
REQ-029 SHALL abandon an operation on reset mid-operation with no done pulse; cmd_ready SHALL be 1 on the first cycle after rst falls if abort=0.

Configuration
REQ-030 SHALL, with COUNT_CTRL_PAUSE_EN defined, add port pause (input, 1 bit); in RUN, pause=1 forces en=0, holds the state, and suppresses the RUN->DONE transition; pause is ignored in other states.
REQ-031 SHALL, without COUNT_CTRL_PAUSE_EN, have no pause port, and RUN behaves per REQ-019/REQ-020.

Structure
REQ-032 SHALL take the state enum typedef (IDLE, LOAD, RUN, DONE) from the shared package count_ctrl_pkg.
REQ-033 SHALL contain no sub-module; the counter is instantiated externally, with its count output wired back to the count input.

Verification
REQ-034 SHALL cover: WIDTH=8, start=10, stop=14 -> load=1 with load_value=10 for one cycle, en=1 for 4 cycles, one done pulse 7 cycles after the handshake, then cmd_ready=1.
REQ-035 SHALL cover: start=7, stop=7 -> en never asserted, done pulse 3 cycles after the handshake.
REQ-036 SHALL cover: start=250, stop=3 -> 9 en cycles with count passing 255 -> 0, then done.
REQ-037 SHALL cover: abort=1 after 2 en cycles of a 10->20 run -> en=0 and busy=0 next cycle, no done, cmd_ready=1.
REQ-038 SHALL cover: rst=1 mid-RUN between clock edges -> en, busy and load go to 0 immediately; after rst falls, state is IDLE.
REQ-039 SHALL cover: with COUNT_CTRL_PAUSE_EN, start=0, stop=5, pause=1 for 3 RUN cycles -> still exactly 5 en cycles, done delayed by 3 cycles.
